// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding a
// 4-digit display mux. Optional raw-hex bypass port enabled by BIN2BCD_HEX_BYPASS_EN.
module bin2bcd_seq #(
    parameter int         IN_W     = 14,
    parameter logic [3:0] DOT_MASK = 4'b0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] bin_in,
    input  logic            load,
`ifdef BIN2BCD_HEX_BYPASS_EN
    input  logic            hex_mode,
`endif
    output logic            ready,
    output logic [15:0]     out_val,
    output logic [3:0]      out_dot,
    output logic            valid,
    output logic            overflow
);

    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t            state;
    logic [IN_W-1:0]   shreg;
    logic [15:0]       bcd;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_pend;
    logic              hex_pend;

    logic [15:0]       bcd_adj;
    logic [IN_W+15:0]  shifted;
    logic              in_big;
    logic              hex_req;

    function automatic logic [15:0] add3_digits(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int d = 0; d < 4; d++) begin
            if (v[d*4 +: 4] >= 4'd5)
                r[d*4 +: 4] = v[d*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [15:0] zext_hex(input logic [IN_W-1:0] v);
        return {{(16-IN_W){1'b0}}, v};
    endfunction

    always_comb begin
        bcd_adj = add3_digits(bcd);
        shifted = {bcd_adj, shreg} << 1;
        in_big  = ({{(32-IN_W){1'b0}}, bin_in} > 32'd9999);
`ifdef BIN2BCD_HEX_BYPASS_EN
        hex_req = hex_mode;
`else
        hex_req = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            valid    <= 1'b0;
            overflow <= 1'b0;
            out_val  <= 16'h0000;
            out_dot  <= 4'b0000;
            shreg    <= '0;
            bcd      <= 16'h0000;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            hex_pend <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg    <= bin_in;
                        bcd      <= 16'h0000;
                        cnt      <= CNT_W'(IN_W);
                        ready    <= 1'b0;
                        hex_pend <= hex_req;
                        // Hex bypass never saturates, so the range flag is masked off.
                        ovf_pend <= in_big && !hex_req;
                        state    <= hex_req ? DONE : CONV;
                    end
                end
                CONV: begin
                    bcd   <= shifted[IN_W+15:IN_W];
                    shreg <= shifted[IN_W-1:0];
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    // Outputs change only here, so the display never sees a partial result.
                    if (hex_pend) begin
                        out_val  <= zext_hex(shreg);
                        out_dot  <= DOT_MASK;
                        overflow <= 1'b0;
                    end else if (ovf_pend) begin
                        out_val  <= 16'h9999;
                        out_dot  <= 4'b1111;
                        overflow <= 1'b1;
                    end else begin
                        out_val  <= bcd;
                        out_dot  <= DOT_MASK;
                        overflow <= 1'b0;
                    end
                    valid <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: table vectors, random values against an
// arithmetic decimal model, held-load throughput and mid-conversion reset.
module tb_bin2bcd_seq;

    localparam int         IN_W = 14;
    localparam logic [3:0] DOT  = 4'b0010;
    localparam int         LAT  = IN_W + 1;

    logic            clk;
    logic            rst;
    logic [IN_W-1:0] bin_in;
    logic            load;
`ifdef BIN2BCD_HEX_BYPASS_EN
    logic            hex_mode;
`endif
    logic            ready;
    logic [15:0]     out_val;
    logic [3:0]      out_dot;
    logic            valid;
    logic            overflow;

    int checks;
    int errors;

    bin2bcd_seq #(.IN_W(IN_W), .DOT_MASK(DOT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bin_in   (bin_in),
        .load     (load),
`ifdef BIN2BCD_HEX_BYPASS_EN
        .hex_mode (hex_mode),
`endif
        .ready    (ready),
        .out_val  (out_val),
        .out_dot  (out_dot),
        .valid    (valid),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          bin;
        logic [15:0] val;
        logic [3:0]  dot;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal digits from plain division, saturating above 9999.
    function automatic logic [15:0] ref_val(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic run_conv(input int v, input bit hex, input logic [15:0] ev,
                            input logic [3:0] ed, input logic eo, input string tag);
        int n;
        bin_in = IN_W'(v);
        load   = 1'b1;
`ifdef BIN2BCD_HEX_BYPASS_EN
        hex_mode = hex;
`endif
        step();
        load   = 1'b0;
        bin_in = IN_W'($urandom);
`ifdef BIN2BCD_HEX_BYPASS_EN
        hex_mode = 1'b0;
`endif
        chk({tag, "_busy"}, 32'(ready), 32'd0);
        n = 0;
        do begin
            step();
            n++;
        end while (!valid && n < 40);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_latency"}, n, hex ? 1 : LAT);
        chk({tag, "_val"}, 32'(out_val), 32'(ev));
        chk({tag, "_dot"}, 32'(out_dot), 32'(ed));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        step();
        chk({tag, "_pulse"}, 32'(valid), 32'd0);
        chk({tag, "_hold"}, 32'(out_val), 32'(ev));
    endtask

    initial begin
        vec_t tbl[8];
        int   q_val[$];
        int   q_idx[$];
        int   nvalid;
        int   v;
        int   acc_v;
        int   acc_i;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        load   = 1'b0;
        bin_in = '0;
`ifdef BIN2BCD_HEX_BYPASS_EN
        hex_mode = 1'b0;
`endif
        tbl[0] = '{1234,  16'h1234, DOT,     1'b0};
        tbl[1] = '{9999,  16'h9999, DOT,     1'b0};
        tbl[2] = '{0,     16'h0000, DOT,     1'b0};
        tbl[3] = '{10000, 16'h9999, 4'b1111, 1'b1};
        tbl[4] = '{42,    16'h0042, DOT,     1'b0};
        tbl[5] = '{16383, 16'h9999, 4'b1111, 1'b1};
        tbl[6] = '{1,     16'h0001, DOT,     1'b0};
        tbl[7] = '{5080,  16'h5080, DOT,     1'b0};

        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_val", 32'(out_val), 32'h0);
        chk("rst_dot", 32'(out_dot), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 8; i++)
            run_conv(tbl[i].bin, 1'b0, tbl[i].val, tbl[i].dot, tbl[i].ovf, $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++) begin
            v = (i % 4 == 0) ? int'($urandom_range(9990, 16383)) : int'($urandom_range(0, 9999));
            run_conv(v, 1'b0, ref_val(v), (v > 9999) ? 4'b1111 : DOT, v > 9999,
                     $sformatf("rnd%0d", i));
        end

        // load held high: only values presented while ready=1 are taken.
        nvalid = 0;
        load = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bin_in = IN_W'($urandom_range(0, 9999));
            if (ready) begin
                q_val.push_back(int'(bin_in));
                q_idx.push_back(i);
            end
            step();
            if (valid) begin
                nvalid++;
                if (q_val.size() == 0) begin
                    chk("held_spurious", 32'd1, 32'd0);
                end else begin
                    acc_v = q_val.pop_front();
                    acc_i = q_idx.pop_front();
                    chk("held_val", 32'(out_val), 32'(ref_val(acc_v)));
                    chk("held_spacing", i - acc_i, LAT);
                end
            end
        end
        load = 1'b0;
        chk("held_count", nvalid, 4);
        step();
        step();

        // Reset in the 6th conversion cycle aborts without a pulse.
        bin_in = IN_W'(1234);
        load   = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_val", 32'(out_val), 32'h0);
        chk("abort_dot", 32'(out_dot), 32'h0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid) nvalid++;
        end
        chk("abort_no_valid", nvalid, 0);
        run_conv(56, 1'b0, 16'h0056, DOT, 1'b0, "after_abort");

`ifdef BIN2BCD_HEX_BYPASS_EN
        run_conv(14'h1ABC, 1'b1, 16'h1ABC, DOT, 1'b0, "hex");
        run_conv(14'h3FFF, 1'b1, 16'h3FFF, DOT, 1'b0, "hex_big");
        run_conv(77, 1'b0, 16'h0077, DOT, 1'b0, "after_hex");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
